ssd_scan_decoder: RTL and testbench

- Receiving end of the multiplexed seven-segment interface.
- Watches a 4-digit scan bus: active-low anodes `an[3:0]` plus active-low segments `a..g`.
- Reconstructs the four displayed hex digits and flags blank, unrecognised and illegal-scan conditions.
- Used in test wrappers to check display drivers in closed loop on Basys 3 at 100 MHz.

---
 rtl/ssd_scan_decoder.sv | 110 +++++++++++
 tb/tb_ssd_scan_decoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers four hex digits from a multiplexed active-low seven-segment scan bus
module ssd_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 262144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] lit,
  output logic [3:0] seen,
  output logic       frame_done,
  output logic       glyph_err,
  output logic       scan_err,
  output logic       stalled
);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  logic [6:0] seg;
  logic [10:0] s, p;
  logic [15:0] cnt, cnt_nxt;
  logic captured, cap, single, multi, hit;
  logic [3:0] nan, seen_new, val;
  logic [1:0] idx;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [3:0] digit_r [4];
  assign seg = {a, b, c, d, e, f, g};
  assign s = {an, seg};
  assign nan = ~an;
  assign single = nan != 4'd0 && (nan & (nan - 4'd1)) == 4'd0;
  assign multi = nan != 4'd0 && !single;
  assign idx = nan[1] ? 2'd1 : nan[2] ? 2'd2 : nan[3] ? 2'd3 : 2'd0;
  assign seen_new = seen | nan;
  assign cnt_nxt = s != p ? 16'd1 : cnt == 16'(SETTLE_CYCLES) ? cnt : cnt + 16'd1;
  assign cap = s == p && cnt_nxt == 16'(SETTLE_CYCLES) && !captured;
  assign tmo_nxt = tmo == TW'(FRAME_TIMEOUT) ? tmo : tmo + TW'(1);
  assign digit0 = digit_r[0];
  assign digit1 = digit_r[1];
  assign digit2 = digit_r[2];
  assign digit3 = digit_r[3];
  always_comb begin
    val = 4'd0;
    hit = 1'b1;
    case (seg)
      7'b0000001: val = 4'h0;
      7'b1001111: val = 4'h1;
      7'b0010010: val = 4'h2;
      7'b0000110: val = 4'h3;
      7'b1001100: val = 4'h4;
      7'b0100100: val = 4'h5;
      7'b0100000: val = 4'h6;
      7'b0001111: val = 4'h7;
      7'b0000000: val = 4'h8;
      7'b0000100: val = 4'h9;
      7'b0001000: val = 4'hA;
      7'b1100000: val = 4'hB;
      7'b0110001: val = 4'hC;
      7'b1000010: val = 4'hD;
      7'b0110000: val = 4'hE;
      7'b0111000: val = 4'hF;
      default:    hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= 11'h7ff;
      cnt <= 16'd0;
      captured <= 1'b0;
      digit_r <= '{default: 4'd0};
      lit <= 4'd0;
      seen <= 4'd0;
      frame_done <= 1'b0;
      glyph_err <= 1'b0;
      scan_err <= 1'b0;
      stalled <= 1'b0;
      tmo <= '0;
    end else begin
      p <= s;
      cnt <= cnt_nxt;
      captured <= s != p ? 1'b0 : captured | cap;
      frame_done <= 1'b0;
      glyph_err <= 1'b0;
      scan_err <= cap && multi;
      if (cap && single) begin
        if (hit) digit_r[idx] <= val;
        lit[idx] <= hit;
        glyph_err <= !hit && seg != 7'h7f;
        frame_done <= seen_new == 4'hf;
        seen <= seen_new == 4'hf ? 4'd0 : seen_new;
        tmo <= '0;
        stalled <= 1'b0;
      end else begin
        tmo <= tmo_nxt;
        if (tmo_nxt == TW'(FRAME_TIMEOUT)) begin
          stalled <= 1'b1;
          seen <= 4'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed test-plan steps plus random scans against a behavioural model
module tb_ssd_scan_decoder;
  localparam int SC = 4;
  localparam int FT = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] an = 4'hf;
  logic [6:0] seg = 7'h7f;
  logic [3:0] digit0, digit1, digit2, digit3, lit, seen;
  logic frame_done, glyph_err, scan_err, stalled;
  int checks = 0, passed = 0, fails = 0;
  logic [6:0] glyphs [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [10:0] m_prev;
  int m_run, m_tmo;
  logic [3:0] m_dig [4];
  logic [3:0] m_lit, m_seen;
  logic m_fd, m_ge, m_se, m_st;
  ssd_scan_decoder #(.SETTLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .an(an),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .lit(lit), .seen(seen), .frame_done(frame_done), .glyph_err(glyph_err),
    .scan_err(scan_err), .stalled(stalled));
  always #5 clk = ~clk;
  task automatic model_step();
    int zeros, pos, k;
    logic [10:0] smp;
    if (rst) begin
      m_prev = 11'h7ff; m_run = 0; m_tmo = 0;
      m_dig = '{default: 4'd0};
      m_lit = 0; m_seen = 0; m_fd = 0; m_ge = 0; m_se = 0; m_st = 0;
      return;
    end
    m_fd = 0; m_ge = 0; m_se = 0;
    smp = {an, seg};
    m_run = smp == m_prev ? m_run + 1 : 1;
    m_prev = smp;
    m_tmo++;
    zeros = 0; pos = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; pos = i; end
    if (m_run == SC && zeros >= 2) m_se = 1;
    if (m_run == SC && zeros == 1) begin
      k = -1;
      for (int j = 0; j < 16; j++) if (glyphs[j] == seg) k = j;
      if (k >= 0) begin m_dig[pos] = 4'(k); m_lit[pos] = 1; end
      else begin m_lit[pos] = 0; m_ge = seg != 7'h7f; end
      m_seen[pos] = 1;
      if (m_seen == 4'hf) begin m_fd = 1; m_seen = 0; end
      m_tmo = 0; m_st = 0;
    end else if (m_tmo >= FT) begin
      m_st = 1; m_seen = 0;
    end
  endtask
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("digits", {digit3, digit2, digit1, digit0}, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk("lit", 16'(lit), 16'(m_lit));
    chk("seen", 16'(seen), 16'(m_seen));
    chk("flags", 16'({frame_done, glyph_err, scan_err, stalled}), 16'({m_fd, m_ge, m_se, m_st}));
  endtask
  task automatic hold(logic [3:0] an_v, logic [6:0] seg_v, int n);
    an = an_v; seg = seg_v;
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int fd_count;
    rst = 1; tick();
    rst = 0;
    chk("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    an = 4'b1110; seg = glyphs[2];
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) chk("tp1_pre_capture", 16'(lit), 16'h0);
      if (i == 4) chk("tp1_digit0", 16'({lit, digit0}), 16'h12);
    end
    fd_count = 0;
    for (int r = 0; r < 4; r++) begin
      an = ~(4'b1 << r);
      seg = glyphs[r == 0 ? 3 : r == 1 ? 10 : r == 2 ? 15 : 0];
      for (int i = 0; i < 8; i++) begin tick(); fd_count += int'(frame_done); end
    end
    chk("tp2_digits", {digit3, digit2, digit1, digit0}, 16'h0FA3);
    chk("tp2_frame_done_count", 16'(fd_count), 16'd1);
    hold(4'b1101, glyphs[7], 3);
    hold(4'b1101, 7'b0000000, 3);
    chk("tp3_no_capture", 16'(digit1), 16'hA);
    hold(4'b1101, glyphs[8], 4);
    chk("tp3_digit1", 16'(digit1), 16'h8);
    hold(4'b1100, glyphs[1], 6);
    hold(4'b1011, 7'b1010101, 6);
    chk("tp5_digit2_held", 16'({lit[2], digit2}), 16'h0F);
    hold(4'b1011, 7'h7f, 6);
    chk("tp5_blank", 16'({lit[2], seen[2]}), 16'h1);
    hold(4'b1110, glyphs[5], SC);
    hold(4'b1111, 7'h7f, 70);
    chk("tp6_stalled", 16'({stalled, seen}), 16'h10);
    hold(4'b1111, 7'h7f, 3);
    rst = 1; tick(); rst = 0;
    chk("tp6_reset", 16'({stalled, lit, seen}), 16'h0);
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      an = sel < 7 ? ~(4'b1 << $urandom_range(0, 3)) : sel == 7 ? 4'hf : 4'($urandom);
      sel = $urandom_range(0, 9);
      seg = sel < 6 ? glyphs[$urandom_range(0, 15)] : sel < 8 ? 7'h7f : 7'($urandom);
      rst = $urandom_range(0, 99) == 0;
      for (int i = $urandom_range(1, 7); i > 0; i--) tick();
      rst = 0;
      if (n == 200) hold(4'b1111, 7'h7f, FT + 5);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
